// File: rtl/twiddle_butterfly.sv
// Radix-2 DIT butterfly with a Q2.10 twiddle multiply, 3-stage elastic pipeline.
// Optional feature: define BFLY_SAT_EN to saturate P to DATA_W bits (default build wraps).
module twiddle_butterfly #(
    parameter int DATA_W = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     In_Valid,
    output logic                     In_Ready,
    input  logic signed [DATA_W-1:0] A_Real,
    input  logic signed [DATA_W-1:0] A_Img,
    input  logic signed [DATA_W-1:0] B_Real,
    input  logic signed [DATA_W-1:0] B_Img,
    input  logic signed [11:0]       W8_Real,
    input  logic signed [11:0]       W8_Img,
    output logic                     Out_Valid,
    input  logic                     Out_Ready,
    output logic signed [DATA_W:0]   Y0_Real,
    output logic signed [DATA_W:0]   Y0_Img,
    output logic signed [DATA_W:0]   Y1_Real,
    output logic signed [DATA_W:0]   Y1_Img,
    output logic                     Sat_Flag
);

`ifdef BFLY_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    localparam int PW = DATA_W + 12;
    localparam int FW = DATA_W + 13;
    localparam logic signed [FW-1:0] HALF = FW'(512);
    localparam logic signed [FW-1:0] MAXV = FW'((longint'(1) <<< (DATA_W - 1)) - 1);
    localparam logic signed [FW-1:0] MINV = -MAXV - FW'(1);

    logic advance;
    assign advance  = ~Out_Valid | Out_Ready;
    assign In_Ready = advance;

    // Operands widened to the product width so the multiply is done at full precision.
    logic signed [PW-1:0] br_x, bi_x, wr_x, wi_x;
    assign br_x = PW'(B_Real);
    assign bi_x = PW'(B_Img);
    assign wr_x = PW'(W8_Real);
    assign wi_x = PW'(W8_Img);

    logic                     s1_v;
    logic signed [PW-1:0]     s1_rr, s1_ii, s1_ri, s1_ir;
    logic signed [DATA_W-1:0] s1_a_re, s1_a_im;

    logic                     s2_v;
    logic signed [DATA_W-1:0] s2_p_re, s2_p_im;
    logic signed [DATA_W-1:0] s2_a_re, s2_a_im;

    logic sat_q;

    logic signed [FW-1:0] p_re_full, p_im_full, p_re_sh, p_im_sh;
    assign p_re_full = {s1_rr[PW-1], s1_rr} - {s1_ii[PW-1], s1_ii};
    assign p_im_full = {s1_ri[PW-1], s1_ri} + {s1_ir[PW-1], s1_ir};
    assign p_re_sh   = (p_re_full + HALF) >>> 10;
    assign p_im_sh   = (p_im_full + HALF) >>> 10;

    logic                     clip_re, clip_im;
    logic signed [DATA_W-1:0] p_re_red, p_im_red;

    always_comb begin
        clip_re  = (p_re_sh > MAXV) || (p_re_sh < MINV);
        clip_im  = (p_im_sh > MAXV) || (p_im_sh < MINV);
        p_re_red = p_re_sh[DATA_W-1:0];
        p_im_red = p_im_sh[DATA_W-1:0];
        if (SAT_EN) begin
            if (p_re_sh > MAXV) p_re_red = MAXV[DATA_W-1:0];
            if (p_re_sh < MINV) p_re_red = MINV[DATA_W-1:0];
            if (p_im_sh > MAXV) p_im_red = MAXV[DATA_W-1:0];
            if (p_im_sh < MINV) p_im_red = MINV[DATA_W-1:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_v      <= 1'b0;
            s1_rr     <= '0;
            s1_ii     <= '0;
            s1_ri     <= '0;
            s1_ir     <= '0;
            s1_a_re   <= '0;
            s1_a_im   <= '0;
            s2_v      <= 1'b0;
            s2_p_re   <= '0;
            s2_p_im   <= '0;
            s2_a_re   <= '0;
            s2_a_im   <= '0;
            Out_Valid <= 1'b0;
            Y0_Real   <= '0;
            Y0_Img    <= '0;
            Y1_Real   <= '0;
            Y1_Img    <= '0;
            sat_q     <= 1'b0;
        end else if (advance) begin
            s1_v      <= In_Valid;
            s1_rr     <= br_x * wr_x;
            s1_ii     <= bi_x * wi_x;
            s1_ri     <= br_x * wi_x;
            s1_ir     <= bi_x * wr_x;
            s1_a_re   <= A_Real;
            s1_a_im   <= A_Img;
            s2_v      <= s1_v;
            s2_p_re   <= p_re_red;
            s2_p_im   <= p_im_red;
            s2_a_re   <= s1_a_re;
            s2_a_im   <= s1_a_im;
            Out_Valid <= s2_v;
            Y0_Real   <= {s2_a_re[DATA_W-1], s2_a_re} + {s2_p_re[DATA_W-1], s2_p_re};
            Y0_Img    <= {s2_a_im[DATA_W-1], s2_a_im} + {s2_p_im[DATA_W-1], s2_p_im};
            Y1_Real   <= {s2_a_re[DATA_W-1], s2_a_re} - {s2_p_re[DATA_W-1], s2_p_re};
            Y1_Img    <= {s2_a_im[DATA_W-1], s2_a_im} - {s2_p_im[DATA_W-1], s2_p_im};
            // Only a real sample clipping in the S2 load counts; bubbles never set the flag.
            if (SAT_EN && s1_v && (clip_re || clip_im))
                sat_q <= 1'b1;
        end
    end

    assign Sat_Flag = SAT_EN ? sat_q : 1'b0;

endmodule
